sar_scan_sequencer: RTL and testbench
=====================================

# sar_scan_sequencer

Multi-channel scan scheduler that sits in front of the `SAR_ADC` controller and shares the single SAR converter between `NUM_CH` analog inputs through an external analog mux. It walks enabled channels round-robin, waits for mux settling, issues `start` pulses, collects `Dout` on `den`, averages `2**AVG_LOG2` conversions per channel and emits one tagged result per channel. It also aborts stuck conversions with a timeout.

## Interface
- `ADC_WIDTH`, 8, SAR resolution; must match the attached `SAR_ADC`.
- `NUM_CH`, 4, number of mux inputs (2..16).
- `CH_W`, 2, channel index width, `$clog2(NUM_CH)`.
- `SETTLE_CYC`, 2, mux settle cycles after each channel change (>=1).
- `AVG_LOG2`, 2, log2 of conversions averaged per channel (0..4).
- `TIMEOUT_CYC`, 20, max cycles in WAIT before abort.

Ports:
- `clk`  in  1  single clock, all logic on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `en`  in  1  level; run continuous scans while high.
- `single`  in  1  level, sampled at scan start; 1 = stop after one scan.
- `ch_mask`  in  NUM_CH  channel enables, latched at scan start.
- `mux_sel`  out  CH_W  analog mux select.
- `adc_start`  out  1  one-cycle start pulse to `SAR_ADC.start`.
- `adc_den`  in  1  `SAR_ADC.den`; `adc_dout` valid while high.
- `adc_dout`  in  ADC_WIDTH  `SAR_ADC.Dout`.
- `res_valid`  out  1  one-cycle result strobe.
- `res_ch`  out  CH_W  channel of the result.
- `res_data`  out  ADC_WIDTH  averaged code.
- `scan_done`  out  1  one-cycle pulse after the last enabled channel.
- `timeout_err`  out  1  one-cycle pulse on a conversion abort.
- `busy`  out  1  high in every state except IDLE.

## Operation
- States: IDLE, SELECT, SETTLE, START, WAIT, ACC, OUT.
- IDLE: if `en`=1 and `ch_mask`!=0, latch `ch_mask` and `single`, set the scan pointer to 0, and go to SELECT. If `ch_mask`=0, stay in IDLE and never pulse `adc_start`.
- SELECT: find the lowest enabled channel >= the pointer. Load `mux_sel`, clear the accumulator and sample counter, then go to SETTLE. If no channel remains, pulse `scan_done`. Then go to IDLE if `single`=1 or `en`=0. Otherwise relatch `ch_mask` and `single`, wrap the pointer to 0, and re-SELECT.
- SETTLE: count `SETTLE_CYC` cycles, then go to START. SETTLE is entered only on a channel change, not between averaged samples.
- START: `adc_start`=1 for exactly this cycle, then go to WAIT.
- WAIT: on `adc_den`=1, capture `adc_dout` and go to ACC. If `TIMEOUT_CYC` cycles pass without `den`, pulse `timeout_err`, discard this channel (no `res_valid`), advance the pointer, and go to SELECT.
- ACC: `acc += adc_dout`. The accumulator is `ADC_WIDTH+AVG_LOG2` bits and cannot overflow. If samples < `2**AVG_LOG2`, go to START; else go to OUT.
- OUT: `res_data = acc >> AVG_LOG2` (floor), `res_ch = mux_sel`, `res_valid`=1. Advance the pointer to channel+1 and go to SELECT.
- `en` falling mid-scan: the current scan completes normally and the block then returns to IDLE.
- `adc_den` outside WAIT is ignored.
- `ch_mask` and `single` changes mid-scan have no effect until the next scan start.

## Timing
- Reset values: `mux_sel`=0, `adc_start`=0, `res_valid`=0, `res_ch`=0, `res_data`=0, `scan_done`=0, `timeout_err`=0, `busy`=0; state IDLE. Reset takes effect immediately, including mid-conversion. Any pending result is dropped.
- All outputs are registered.
- `en` sampled high at edge k (IDLE) → SELECT at k+1 → `mux_sel` valid and SETTLE at k+2.
- `adc_start` is high in cycle k+2+`SETTLE_CYC`.
- `den` in cycle d → ACC at d+1.
- After the last sample: `res_valid` is high in cycle d+2.
- Back-to-back samples: `adc_start` follows `den` by 2 cycles (ACC, START).
- `scan_done` is high 1 cycle after the last channel's OUT (its SELECT cycle).
- `res_valid` and `scan_done` are never high in the same cycle.

## Test plan
- `NUM_CH`=4, `AVG_LOG2`=0, `ch_mask`=4'b1111, `single`=1, comparator model with codes {153,0,255,77} → 4 `res_valid` with `res_ch` 0,1,2,3 and data 153,0,255,77, then one `scan_done` and `busy`=0.
- `ch_mask`=4'b1010, `AVG_LOG2`=2, ch1 model returns 10,11,12,13 on successive conversions → `res_ch`=1, `res_data`=11. Exactly 4 `adc_start` pulses per channel; ch0 and ch2 are never selected.
- `ch_mask`=0, `en`=1 for 50 cycles → `adc_start` never pulses and `busy` stays 0.
- Model withholds `den` on ch2 → `timeout_err` pulses `TIMEOUT_CYC` cycles after that START. No result is emitted for ch2, and ch3 converts normally.
- `en`=1, `single`=0, `en` dropped during ch1 → ch1..ch3 complete, then `scan_done` and IDLE. `rst` asserted during WAIT clears all outputs within the same cycle.

Source files
------------

// File: rtl/sar_scan_sequencer.sv
// Round-robin scan scheduler sharing one SAR ADC across an analog mux: select, settle,
// convert, average 2**AVG_LOG2 samples and emit one tagged result per enabled channel.
module sar_scan_sequencer #(
   parameter int ADC_WIDTH   = 8,
   parameter int NUM_CH      = 4,
   parameter int CH_W        = 2,
   parameter int SETTLE_CYC  = 2,
   parameter int AVG_LOG2    = 2,
   parameter int TIMEOUT_CYC = 20
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 en,
   input  logic                 single,
   input  logic [NUM_CH-1:0]    ch_mask,
   output logic [CH_W-1:0]      mux_sel,
   output logic                 adc_start,
   input  logic                 adc_den,
   input  logic [ADC_WIDTH-1:0] adc_dout,
   output logic                 res_valid,
   output logic [CH_W-1:0]      res_ch,
   output logic [ADC_WIDTH-1:0] res_data,
   output logic                 scan_done,
   output logic                 timeout_err,
   output logic                 busy
);

   localparam int ACC_W    = ADC_WIDTH + AVG_LOG2;
   localparam int CNT_W    = AVG_LOG2 + 1;
   localparam int PTR_W    = CH_W + 1;
   localparam int SETTLE_W = $clog2(SETTLE_CYC + 1);
   localparam int WAIT_W   = $clog2(TIMEOUT_CYC + 1);
   localparam int NSAMP    = 1 << AVG_LOG2;

   typedef enum logic [2:0] {
      S_IDLE, S_SELECT, S_SETTLE, S_START, S_WAIT, S_ACC, S_OUT
   } state_t;

   typedef struct packed {
      logic            found;
      logic [CH_W-1:0] idx;
   } hit_t;

   state_t               state, state_n;
   logic [NUM_CH-1:0]    mask_q;
   logic                 single_q;
   logic [PTR_W-1:0]     ptr;
   logic [ACC_W-1:0]     acc;
   logic [ADC_WIDTH-1:0] sample_q;
   logic [CNT_W-1:0]     sample_cnt;
   logic [SETTLE_W-1:0]  settle_cnt;
   logic [WAIT_W-1:0]    wait_cnt;

   logic                 adc_start_d, res_valid_d, scan_done_d, timeout_d, busy_d;
   logic                 relatch, last_sample, wait_expired;
   logic [PTR_W-1:0]     ptr_after;
   logic [ACC_W-1:0]     acc_sum;
   hit_t                 sel_hit, next_hit;

   // Lowest enabled channel at or above the pointer; descending scan lets the lowest win.
   function automatic hit_t find_ch(input logic [NUM_CH-1:0] m, input logic [PTR_W-1:0] p);
      hit_t h;
      h = '0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (m[i] && i >= int'(p)) begin
            h.found = 1'b1;
            h.idx   = CH_W'(i);
         end
      end
      return h;
   endfunction

   assign ptr_after    = {1'b0, mux_sel} + PTR_W'(1);
   assign sel_hit      = find_ch(mask_q, ptr);
   assign next_hit     = find_ch(mask_q, ptr_after);
   assign acc_sum      = acc + ACC_W'(sample_q);
   assign last_sample  = (sample_cnt == CNT_W'(NSAMP - 1));
   assign wait_expired = (wait_cnt == WAIT_W'(TIMEOUT_CYC - 1));

   // NOTE: sequential state uses <= so every flop samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_n;
   end

   always_comb begin
      // NOTE: default first so every path assigns state_n and no latch is inferred.
      state_n = state;
      case (state)
         S_IDLE:   if (en && |ch_mask) state_n = S_SELECT;
         S_SELECT: begin
            if (sel_hit.found)                             state_n = S_SETTLE;
            else if (single_q || !en || ch_mask == '0)     state_n = S_IDLE;
            else                                           state_n = S_SELECT;
         end
         S_SETTLE: if (settle_cnt == SETTLE_W'(SETTLE_CYC - 1)) state_n = S_START;
         S_START:  state_n = S_WAIT;
         S_WAIT: begin
            if (adc_den)           state_n = S_ACC;
            else if (wait_expired) state_n = S_SELECT;
         end
         S_ACC:    state_n = last_sample ? S_OUT : S_START;
         S_OUT:    state_n = S_SELECT;
         default:  state_n = S_IDLE;
      endcase
   end

   // Outputs are decoded from the upcoming state and registered, so they line up with it.
   always_comb begin
      adc_start_d = (state_n == S_START);
      res_valid_d = (state_n == S_OUT);
      timeout_d   = (state == S_WAIT) && (state_n == S_SELECT);
      scan_done_d = ((state == S_OUT) || timeout_d) && !next_hit.found;
      busy_d      = (state_n != S_IDLE);
      relatch     = (state_n == S_SELECT) && (state == S_IDLE || state == S_SELECT);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mux_sel     <= '0;
         adc_start   <= 1'b0;
         res_valid   <= 1'b0;
         res_ch      <= '0;
         res_data    <= '0;
         scan_done   <= 1'b0;
         timeout_err <= 1'b0;
         busy        <= 1'b0;
         mask_q      <= '0;
         single_q    <= 1'b0;
         ptr         <= '0;
         acc         <= '0;
         sample_q    <= '0;
         sample_cnt  <= '0;
         settle_cnt  <= '0;
         wait_cnt    <= '0;
      end else begin
         adc_start   <= adc_start_d;
         res_valid   <= res_valid_d;
         scan_done   <= scan_done_d;
         timeout_err <= timeout_d;
         busy        <= busy_d;
         if (relatch) begin
            mask_q   <= ch_mask;
            single_q <= single;
            ptr      <= '0;
         end
         case (state)
            S_SELECT: if (sel_hit.found) begin
               mux_sel    <= sel_hit.idx;
               acc        <= '0;
               sample_cnt <= '0;
               settle_cnt <= '0;
            end
            S_SETTLE: settle_cnt <= settle_cnt + SETTLE_W'(1);
            S_START:  wait_cnt <= WAIT_W'(1);
            S_WAIT: begin
               wait_cnt <= wait_cnt + WAIT_W'(1);
               if (adc_den)           sample_q <= adc_dout;
               else if (wait_expired) ptr      <= ptr_after;
            end
            S_ACC: begin
               acc        <= acc_sum;
               sample_cnt <= sample_cnt + CNT_W'(1);
               if (last_sample) begin
                  res_data <= ADC_WIDTH'(acc_sum >> AVG_LOG2);
                  res_ch   <= mux_sel;
               end
            end
            S_OUT:    ptr <= ptr_after;
            default:  ;
         endcase
      end
   end

endmodule

// File: tb/tb_sar_scan_sequencer.sv
// Self-checking bench: a behavioural SAR ADC responder with random latency, a result
// monitor, and a per-scan reference built from channel mask and code tables.
`timescale 1ns/1ps
module tb_sar_scan_sequencer;

   localparam int ADC_WIDTH   = 8;
   localparam int NUM_CH      = 4;
   localparam int CH_W        = 2;
   localparam int SETTLE_CYC  = 2;
   localparam int AVG_LOG2    = 2;
   localparam int TIMEOUT_CYC = 20;
   localparam int NSAMP       = 1 << AVG_LOG2;

   logic                 clk = 1'b0;
   logic                 rst, en, single;
   logic [NUM_CH-1:0]    ch_mask;
   logic [CH_W-1:0]      mux_sel;
   logic                 adc_start, adc_den;
   logic [ADC_WIDTH-1:0] adc_dout;
   logic                 res_valid;
   logic [CH_W-1:0]      res_ch;
   logic [ADC_WIDTH-1:0] res_data;
   logic                 scan_done, timeout_err, busy;

   sar_scan_sequencer #(
      .ADC_WIDTH(ADC_WIDTH), .NUM_CH(NUM_CH), .CH_W(CH_W),
      .SETTLE_CYC(SETTLE_CYC), .AVG_LOG2(AVG_LOG2), .TIMEOUT_CYC(TIMEOUT_CYC)
   ) dut (
      .clk(clk), .rst(rst), .en(en), .single(single), .ch_mask(ch_mask),
      .mux_sel(mux_sel), .adc_start(adc_start), .adc_den(adc_den), .adc_dout(adc_dout),
      .res_valid(res_valid), .res_ch(res_ch), .res_data(res_data),
      .scan_done(scan_done), .timeout_err(timeout_err), .busy(busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int failures = 0;

   int codes [NUM_CH][NSAMP];
   bit withhold [NUM_CH];
   bit spurious = 1'b0;
   int starts [NUM_CH];
   int start_cyc_q[$], start_ch_q[$], den_cyc_q[$];
   int res_ch_q[$], res_data_q[$], res_cyc_q[$];
   int exp_ch_q[$], exp_data_q[$];
   int done_cnt, done_cyc, to_cnt, to_cyc, overlap_cnt;
   bit busy_seen;

   // ADC responder: answers each start after 1..8 cycles unless the channel is withheld.
   initial begin
      int ch, k, lat;
      adc_den  = 1'b0;
      adc_dout = '0;
      forever begin
         @(posedge clk); #1;
         if (adc_start === 1'b1 && !rst) begin
            adc_den = 1'b0;
            ch = int'(mux_sel);
            start_cyc_q.push_back(cyc);
            start_ch_q.push_back(ch);
            k = starts[ch] % NSAMP;
            starts[ch]++;
            if (!withhold[ch]) begin
               lat = $urandom_range(1, 8);
               repeat (lat) @(posedge clk);
               #1;
               adc_den  = 1'b1;
               adc_dout = ADC_WIDTH'(codes[ch][k]);
               den_cyc_q.push_back(cyc);
               @(posedge clk); #1;
               adc_den  = 1'b0;
               adc_dout = ADC_WIDTH'($urandom);
            end
         end else if (spurious) begin
            adc_den  = 1'($urandom_range(0, 1));
            adc_dout = ADC_WIDTH'($urandom);
         end else begin
            adc_den = 1'b0;
         end
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
         if (res_valid) begin
            res_ch_q.push_back(int'(res_ch));
            res_data_q.push_back(int'(res_data));
            res_cyc_q.push_back(cyc);
         end
         if (scan_done)   begin done_cnt++; done_cyc = cyc; end
         if (timeout_err) begin to_cnt++;   to_cyc   = cyc; end
         if (res_valid && scan_done) overlap_cnt++;
         if (busy) busy_seen = 1'b1;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   task automatic clear_obs();
      start_cyc_q.delete(); start_ch_q.delete(); den_cyc_q.delete();
      res_ch_q.delete(); res_data_q.delete(); res_cyc_q.delete();
      done_cnt = 0; to_cnt = 0; overlap_cnt = 0; busy_seen = 1'b0;
      done_cyc = 0; to_cyc = 0;
      for (int c = 0; c < NUM_CH; c++) starts[c] = 0;
   endtask

   task automatic random_codes();
      for (int c = 0; c < NUM_CH; c++)
         for (int k = 0; k < NSAMP; k++) codes[c][k] = $urandom_range(0, 255);
   endtask

   // Reference: each enabled, responding channel in ascending order yields floor(mean of its codes).
   task automatic build_expected(input logic [NUM_CH-1:0] m, input int nscans);
      exp_ch_q.delete(); exp_data_q.delete();
      for (int s = 0; s < nscans; s++)
         for (int c = 0; c < NUM_CH; c++)
            if (m[c] && !withhold[c]) begin
               int sum = 0;
               for (int k = 0; k < NSAMP; k++) sum += codes[c][k];
               exp_ch_q.push_back(c);
               exp_data_q.push_back(sum / NSAMP);
            end
   endtask

   task automatic wait_done(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (scan_done) begin ok = 1'b1; break; end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; en = 1'b0; single = 1'b1; ch_mask = '0;
      for (int c = 0; c < NUM_CH; c++) withhold[c] = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if ({mux_sel, adc_start, res_valid, res_ch, res_data, scan_done, timeout_err, busy} !== '0) begin
         failures++;
         $display("FAIL reset_outputs got mux=%0d st=%0b rv=%0b ch=%0d d=%0d sd=%0b to=%0b busy=%0b want all 0",
                  mux_sel, adc_start, res_valid, res_ch, res_data, scan_done, timeout_err, busy);
      end
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (busy !== 1'b0) begin failures++; $display("FAIL reset_idle busy got=%0b want=0", busy); end
   endtask

   task automatic test_basic();
      int base [NUM_CH] = '{153, 0, 255, 77};
      bit ok;
      for (int c = 0; c < NUM_CH; c++)
         for (int k = 0; k < NSAMP; k++) codes[c][k] = base[c];
      clear_obs();
      ch_mask = 4'b1111; single = 1'b1; en = 1'b1;
      wait_done(3000, ok);
      en = 1'b0;
      repeat (5) @(negedge clk);
      checks++;
      if (!ok) begin failures++; $display("FAIL basic_done got=timeout want=scan_done"); end
      checks++;
      if (busy !== 1'b0 || done_cnt != 1 || overlap_cnt != 0) begin
         failures++;
         $display("FAIL basic_end got busy=%0b done=%0d overlap=%0d want 0/1/0", busy, done_cnt, overlap_cnt);
      end
      build_expected(4'b1111, 1);
      checks++;
      if (res_ch_q.size() != exp_ch_q.size()) begin
         failures++; $display("FAIL basic_count got=%0d want=%0d", res_ch_q.size(), exp_ch_q.size());
      end
      for (int i = 0; i < exp_ch_q.size() && i < res_ch_q.size(); i++) begin
         checks++;
         if (res_ch_q[i] != exp_ch_q[i] || res_data_q[i] != exp_data_q[i]) begin
            failures++;
            $display("FAIL basic_res%0d got ch%0d/%0d want ch%0d/%0d", i, res_ch_q[i], res_data_q[i], exp_ch_q[i], exp_data_q[i]);
         end
      end
      for (int c = 0; c < NUM_CH; c++) begin
         checks++;
         if (starts[c] != NSAMP) begin failures++; $display("FAIL basic_starts ch%0d got=%0d want=%0d", c, starts[c], NSAMP); end
      end
   endtask

   task automatic test_average();
      bit ok;
      random_codes();
      for (int k = 0; k < NSAMP; k++) codes[1][k] = 10 + k;
      clear_obs();
      ch_mask = 4'b1010; single = 1'b1; en = 1'b1;
      wait_done(3000, ok);
      en = 1'b0;
      repeat (5) @(negedge clk);
      checks++;
      if (!ok) begin failures++; $display("FAIL avg_done got=timeout want=scan_done"); end
      checks++;
      if (res_ch_q.size() < 1 || res_ch_q[0] != 1 || res_data_q[0] != 11) begin
         failures++;
         $display("FAIL avg_ch1 got n=%0d ch%0d/%0d want ch1/11", res_ch_q.size(),
                  res_ch_q.size() > 0 ? res_ch_q[0] : -1, res_data_q.size() > 0 ? res_data_q[0] : -1);
      end
      build_expected(4'b1010, 1);
      checks++;
      if (res_ch_q.size() != exp_ch_q.size()) begin
         failures++; $display("FAIL avg_count got=%0d want=%0d", res_ch_q.size(), exp_ch_q.size());
      end
      for (int i = 0; i < exp_ch_q.size() && i < res_ch_q.size(); i++) begin
         checks++;
         if (res_ch_q[i] != exp_ch_q[i] || res_data_q[i] != exp_data_q[i]) begin
            failures++;
            $display("FAIL avg_res%0d got ch%0d/%0d want ch%0d/%0d", i, res_ch_q[i], res_data_q[i], exp_ch_q[i], exp_data_q[i]);
         end
      end
      for (int c = 0; c < NUM_CH; c++) begin
         checks++;
         if (starts[c] != (c % 2 == 1 ? NSAMP : 0)) begin
            failures++; $display("FAIL avg_starts ch%0d got=%0d want=%0d", c, starts[c], c % 2 == 1 ? NSAMP : 0);
         end
      end
   endtask

   task automatic test_random();
      bit ok;
      logic [NUM_CH-1:0] m;
      for (int it = 0; it < 4; it++) begin
         random_codes();
         m = NUM_CH'($urandom_range(1, (1 << NUM_CH) - 1));
         clear_obs();
         ch_mask = m; single = 1'b1; en = 1'b1;
         wait_done(3000, ok);
         en = 1'b0;
         repeat (5) @(negedge clk);
         build_expected(m, 1);
         checks++;
         if (!ok || res_ch_q.size() != exp_ch_q.size() || overlap_cnt != 0) begin
            failures++;
            $display("FAIL rand%0d_count mask=%b done=%0b got=%0d want=%0d overlap=%0d", it, m, ok, res_ch_q.size(), exp_ch_q.size(), overlap_cnt);
         end
         for (int i = 0; i < exp_ch_q.size() && i < res_ch_q.size(); i++) begin
            checks++;
            if (res_ch_q[i] != exp_ch_q[i] || res_data_q[i] != exp_data_q[i]) begin
               failures++;
               $display("FAIL rand%0d_res%0d got ch%0d/%0d want ch%0d/%0d", it, i, res_ch_q[i], res_data_q[i], exp_ch_q[i], exp_data_q[i]);
            end
         end
      end
   endtask

   task automatic test_empty_mask();
      clear_obs();
      ch_mask = '0; single = 1'b0; en = 1'b1; spurious = 1'b1;
      repeat (50) @(negedge clk);
      en = 1'b0; spurious = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (start_cyc_q.size() != 0 || busy_seen || res_ch_q.size() != 0) begin
         failures++;
         $display("FAIL empty_mask got starts=%0d busy_seen=%0b results=%0d want 0/0/0", start_cyc_q.size(), busy_seen, res_ch_q.size());
      end
   endtask

   task automatic test_timeout();
      bit ok;
      int s2 = -1;
      random_codes();
      withhold[2] = 1'b1;
      clear_obs();
      ch_mask = 4'b1111; single = 1'b1; en = 1'b1;
      wait_done(4000, ok);
      en = 1'b0;
      repeat (5) @(negedge clk);
      foreach (start_ch_q[i]) if (start_ch_q[i] == 2 && s2 < 0) s2 = start_cyc_q[i];
      checks++;
      if (!ok || to_cnt != 1) begin failures++; $display("FAIL to_count done=%0b got=%0d want=1", ok, to_cnt); end
      checks++;
      if (to_cyc - s2 != TIMEOUT_CYC) begin
         failures++; $display("FAIL to_latency got=%0d want=%0d", to_cyc - s2, TIMEOUT_CYC);
      end
      checks++;
      if (starts[2] != 1 || starts[3] != NSAMP) begin
         failures++; $display("FAIL to_starts got ch2=%0d ch3=%0d want 1/%0d", starts[2], starts[3], NSAMP);
      end
      build_expected(4'b1111, 1);
      checks++;
      if (res_ch_q.size() != exp_ch_q.size()) begin
         failures++; $display("FAIL to_res_count got=%0d want=%0d", res_ch_q.size(), exp_ch_q.size());
      end
      for (int i = 0; i < exp_ch_q.size() && i < res_ch_q.size(); i++) begin
         checks++;
         if (res_ch_q[i] != exp_ch_q[i] || res_data_q[i] != exp_data_q[i]) begin
            failures++;
            $display("FAIL to_res%0d got ch%0d/%0d want ch%0d/%0d", i, res_ch_q[i], res_data_q[i], exp_ch_q[i], exp_data_q[i]);
         end
      end
      withhold[2] = 1'b0;
   endtask

   task automatic test_timing();
      bit ok;
      int c0;
      random_codes();
      clear_obs();
      ch_mask = 4'b0100; single = 1'b1; en = 1'b1;
      c0 = cyc;
      @(negedge clk);
      checks++;
      if (busy !== 1'b1) begin failures++; $display("FAIL tim_busy got=%0b want=1", busy); end
      @(negedge clk);
      checks++;
      if (mux_sel !== 2'd2) begin failures++; $display("FAIL tim_mux got=%0d want=2", mux_sel); end
      wait_done(3000, ok);
      en = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (!ok || start_cyc_q.size() != NSAMP || den_cyc_q.size() != NSAMP || res_cyc_q.size() != 1) begin
         failures++;
         $display("FAIL tim_counts done=%0b got starts=%0d dens=%0d res=%0d want %0d/%0d/1", ok,
                  start_cyc_q.size(), den_cyc_q.size(), res_cyc_q.size(), NSAMP, NSAMP);
      end else begin
         checks++;
         if (start_cyc_q[0] != c0 + 2 + SETTLE_CYC) begin
            failures++; $display("FAIL tim_first_start got=%0d want=%0d", start_cyc_q[0] - c0, 2 + SETTLE_CYC);
         end
         for (int i = 0; i + 1 < NSAMP; i++) begin
            checks++;
            if (start_cyc_q[i + 1] != den_cyc_q[i] + 2) begin
               failures++; $display("FAIL tim_b2b%0d got=%0d want=2", i, start_cyc_q[i + 1] - den_cyc_q[i]);
            end
         end
         checks++;
         if (res_cyc_q[0] != den_cyc_q[NSAMP - 1] + 2 || done_cyc != res_cyc_q[0] + 1) begin
            failures++;
            $display("FAIL tim_res got den->res=%0d res->done=%0d want 2/1", res_cyc_q[0] - den_cyc_q[NSAMP - 1], done_cyc - res_cyc_q[0]);
         end
      end
   endtask

   task automatic test_back_to_back();
      bit ok = 1'b0;
      int seen_done = 0;
      random_codes();
      clear_obs();
      ch_mask = 4'b1111; single = 1'b0; en = 1'b1;
      for (int i = 0; i < 6000; i++) begin
         @(negedge clk);
         if (scan_done) seen_done++;
         if (seen_done == 1 && adc_start && mux_sel == 2'd1) begin ok = 1'b1; break; end
      end
      en = 1'b0; ch_mask = 4'b0001; single = 1'b1;
      checks++;
      if (!ok) begin failures++; $display("FAIL b2b_second_scan got=not_reached want=ch1_start"); end
      wait_done(3000, ok);
      repeat (5) @(negedge clk);
      checks++;
      if (!ok || done_cnt != 2 || busy !== 1'b0 || overlap_cnt != 0) begin
         failures++;
         $display("FAIL b2b_end done=%0b got scans=%0d busy=%0b overlap=%0d want 2/0/0", ok, done_cnt, busy, overlap_cnt);
      end
      build_expected(4'b1111, 2);
      checks++;
      if (res_ch_q.size() != exp_ch_q.size()) begin
         failures++; $display("FAIL b2b_count got=%0d want=%0d", res_ch_q.size(), exp_ch_q.size());
      end
      for (int i = 0; i < exp_ch_q.size() && i < res_ch_q.size(); i++) begin
         checks++;
         if (res_ch_q[i] != exp_ch_q[i] || res_data_q[i] != exp_data_q[i]) begin
            failures++;
            $display("FAIL b2b_res%0d got ch%0d/%0d want ch%0d/%0d", i, res_ch_q[i], res_data_q[i], exp_ch_q[i], exp_data_q[i]);
         end
      end
   endtask

   task automatic test_reset_mid();
      bit ok = 1'b0;
      random_codes();
      clear_obs();
      ch_mask = 4'b1111; single = 1'b1; en = 1'b1;
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         if (adc_start && mux_sel == 2'd2) begin ok = 1'b1; break; end
      end
      @(negedge clk);
      rst = 1'b1; en = 1'b0;
      #1;
      checks++;
      if (!ok || {mux_sel, adc_start, res_valid, res_ch, res_data, scan_done, timeout_err, busy} !== '0) begin
         failures++;
         $display("FAIL rst_mid reached=%0b got mux=%0d st=%0b rv=%0b ch=%0d d=%0d sd=%0b to=%0b busy=%0b want all 0",
                  ok, mux_sel, adc_start, res_valid, res_ch, res_data, scan_done, timeout_err, busy);
      end
      clear_obs();
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (40) @(negedge clk);
      checks++;
      if (res_ch_q.size() != 0 || busy_seen || done_cnt != 0) begin
         failures++;
         $display("FAIL rst_drop got results=%0d busy_seen=%0b done=%0d want 0/0/0", res_ch_q.size(), busy_seen, done_cnt);
      end
   endtask

   initial begin
      clear_obs();
      test_reset();
      test_basic();
      test_average();
      test_random();
      test_empty_mask();
      test_timeout();
      test_timing();
      test_back_to_back();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
